// File: rtl/apb_multi_counter.sv
// APB3 timer/counter block: NUM_CH independent counters with load, compare,
// up/down, auto-reload and sticky MATCH/WRAP status driving a maskable irq.
module apb_multi_counter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1'b1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  load_q [NUM_CH];
  logic [CNT_W-1:0]  load_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  cmp_q  [NUM_CH];
  logic [CNT_W-1:0]  cmp_d  [NUM_CH];
  logic [3:0]        ctrl_q [NUM_CH];
  logic [3:0]        ctrl_d [NUM_CH];
  logic [1:0]        stat_q [NUM_CH];
  logic [1:0]        stat_d [NUM_CH];
  logic [31:0]       prdata_q, prdata_d;
  logic [2:0]        reg_s;
  logic [ADDR_W-4:0] ch_s;
  logic [NUM_CH-1:0] sel_s, wsel_s;
  logic              mapped_s, err_s, access_s, wr_s;
  logic [31:0]       rmux_s, val_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // state_d is the bus phase of the current cycle; ACCESS only follows SETUP
  always_comb begin
    state_d = IDLE;
    if (PSEL && !PENABLE) begin
      state_d = SETUP;
    end else if (PSEL && PENABLE && (state_q == SETUP)) begin
      state_d = ACCESS;
    end else begin
      state_d = IDLE;
    end
  end

  always_comb begin
    access_s = (state_d == ACCESS);
    PREADY   = access_s;
    PSLVERR  = access_s && err_s;
    wr_s     = access_s && PWRITE && !err_s;
    wsel_s   = sel_s & {NUM_CH{wr_s}};
  end

  always_comb begin
    reg_s = PADDR[2:0];
    ch_s  = PADDR[ADDR_W-1:3];
    sel_s = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      sel_s[c] = (ch_s == (ADDR_W-3)'(c));
    end
    mapped_s = (|sel_s) && (reg_s < 3'd6);
    err_s    = !mapped_s || (PWRITE && (reg_s == 3'd3));
  end

  always_comb begin
    rmux_s = 32'd0;
    val_s  = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (reg_s)
        3'd0:    val_s = 32'(load_q[c]);
        3'd1:    val_s = 32'(ctrl_q[c]);
        3'd3:    val_s = 32'(cnt_q[c]);
        3'd4:    val_s = 32'(cmp_q[c]);
        3'd5:    val_s = 32'(stat_q[c]);
        default: val_s = 32'd0;
      endcase
      rmux_s = rmux_s | (sel_s[c] ? val_s : 32'd0);
    end
    prdata_d = ((state_d == SETUP) && !PWRITE) ? rmux_s : prdata_q;
  end

  // Counter step uses the CTRL value before any write committing this cycle
  always_comb begin
    logic       ld_v, en_v, wrap_v, match_v;
    logic [1:0] clr_v;
    ld_v    = 1'b0;
    en_v    = 1'b0;
    wrap_v  = 1'b0;
    match_v = 1'b0;
    clr_v   = 2'b00;
    for (int c = 0; c < NUM_CH; c++) begin
      load_d[c] = (wsel_s[c] && (reg_s == 3'd0)) ? PWDATA[CNT_W-1:0] : load_q[c];
      ctrl_d[c] = (wsel_s[c] && (reg_s == 3'd1)) ? PWDATA[3:0] : ctrl_q[c];
      cmp_d[c]  = (wsel_s[c] && (reg_s == 3'd4)) ? PWDATA[CNT_W-1:0] : cmp_q[c];
      ld_v      = wsel_s[c] && (reg_s == 3'd2) && PWDATA[0];
      en_v      = ctrl_q[c][0];
      wrap_v    = 1'b0;
      if (ld_v) begin
        cnt_d[c] = load_q[c];
      end else if (en_v && !ctrl_q[c][1]) begin
        if (cnt_q[c] == ONES) begin
          wrap_v   = 1'b1;
          cnt_d[c] = ctrl_q[c][2] ? load_q[c] : ZERO;
        end else begin
          cnt_d[c] = cnt_q[c] + ONE;
        end
      end else if (en_v) begin
        if (cnt_q[c] == ZERO) begin
          wrap_v   = 1'b1;
          cnt_d[c] = ctrl_q[c][2] ? load_q[c] : ONES;
        end else begin
          cnt_d[c] = cnt_q[c] - ONE;
        end
      end else begin
        cnt_d[c] = cnt_q[c];
      end
      match_v   = en_v && (cnt_q[c] == cmp_q[c]);
      clr_v     = (wsel_s[c] && (reg_s == 3'd5)) ? PWDATA[1:0] : 2'b00;
      stat_d[c] = (stat_q[c] & ~clr_v) | {wrap_v, match_v};
    end
  end

  always_comb begin
    irq = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      irq[c] = |(stat_q[c] & {2{ctrl_q[c][3]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prdata_q <= 32'd0;
      for (int c = 0; c < NUM_CH; c++) begin
        load_q[c] <= ZERO;
        cnt_q[c]  <= ZERO;
        cmp_q[c]  <= ZERO;
        ctrl_q[c] <= 4'd0;
        stat_q[c] <= 2'd0;
      end
    end else begin
      prdata_q <= prdata_d;
      for (int c = 0; c < NUM_CH; c++) begin
        load_q[c] <= load_d[c];
        cnt_q[c]  <= cnt_d[c];
        cmp_q[c]  <= cmp_d[c];
        ctrl_q[c] <= ctrl_d[c];
        stat_q[c] <= stat_d[c];
      end
    end
  end

  assign PRDATA = prdata_q;

endmodule
